seg7_scan_driver_n: RTL and testbench



---
 rtl/seg7_scan_driver_n.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver_n.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_n.sv
// seg7_scan_driver_n: N-digit multiplexed 7-segment driver with frame latch, blanking, PWM dimming and polarity select
module seg7_scan_driver_n #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BRIGHT_W    = 4,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);
  localparam int   PW  = $clog2(REFRESH_DIV);
  localparam int   SW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic INV = ACTIVE_LOW != 0;
  logic [PW-1:0]       presc;
  logic [SW-1:0]       slot;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [4*DIGITS-1:0] bcd_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic                blank_sh;
  logic [BRIGHT_W-1:0] bright_sh;
  logic                wrap, frame_end, on;
  logic                zero_run, dp_cur, blank_cur;
  logic [3:0]          cur;
  logic [6:0]          pat, seg_n;
  logic [DIGITS-1:0]   sel_n;
  logic                dp_n;
  assign wrap      = presc == PW'(REFRESH_DIV - 1);
  assign frame_end = wrap && slot == SW'(DIGITS - 1);
  assign on        = (&bright_sh) || pwm_cnt < bright_sh;
  // select the current slot's shadow digit and decide blanking from the top digit down
  always_comb begin
    zero_run  = 1'b1;
    cur       = 4'd0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && bcd_sh[4*k +: 4] == 4'd0;
      if (slot == SW'(k)) begin
        cur       = bcd_sh[4*k +: 4];
        dp_cur    = dp_sh[k];
        blank_cur = blank_sh && zero_run && k != 0;
      end
    end
  end
  // BCD to {g..a}; non-decimal codes show a dash
  always_comb begin
    case (cur)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b1000000;
    endcase
  end
  assign seg_n = on && !blank_cur ? pat : 7'd0;
  assign dp_n  = on && dp_cur;
  assign sel_n = on ? DIGITS'(1) << slot : '0;
  // prescaler, slot scan and free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      slot    <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= wrap ? '0 : presc + 1'b1;
      slot    <= wrap ? (slot == SW'(DIGITS - 1) ? '0 : slot + 1'b1) : slot;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
  // shadow registers reload only at frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_sh    <= '0;
      dp_sh     <= '0;
      blank_sh  <= 1'b0;
      bright_sh <= '0;
    end else if (frame_end) begin
      bcd_sh    <= bcd;
      dp_sh     <= dp_in;
      blank_sh  <= blank_lz;
      bright_sh <= brightness;
    end
  end
  // registered outputs, polarity applied after PWM gating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{INV}};
      dp         <= INV;
      digit_sel  <= {DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_n ^ {7{INV}};
      dp         <= dp_n ^ INV;
      digit_sel  <= sel_n ^ {DIGITS{INV}};
      frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver_n.sv
// tb_seg7_scan_driver_n: directed checks of scanning, decode, blanking, latching, dimming and polarity
module tb_seg7_scan_driver_n;
  logic        clk = 1'b0;
  logic        rst_n, rst_n_b;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, ft_a, ft_b;
  logic [3:0]  sel_a, sel_b;
  int          asserts = 0;
  int          fails = 0;
  logic [3:0]  gs[16];
  logic [6:0]  gg[16];
  logic        gd[16], gt[16];
  bit          tmo;
  always #5 clk = ~clk;
  seg7_scan_driver_n #(.DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg_a), .dp(dp_a), .digit_sel(sel_a), .frame_tick(ft_a));
  seg7_scan_driver_n #(.DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(4), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg_b), .dp(dp_b), .digit_sel(sel_b), .frame_tick(ft_b));
  task automatic wait_tick(input bit b);
    tmo = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((b ? ft_b : ft_a) === 1'b1) begin
        tmo = 1'b0;
        return;
      end
    end
  endtask
  task automatic grab(input bit b);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      gs[i] = b ? sel_b : sel_a;
      gg[i] = b ? seg_b : seg_a;
      gd[i] = b ? dp_b : dp_a;
      gt[i] = b ? ft_b : ft_a;
    end
  endtask
  task automatic next_frame(input bit b);
    wait_tick(b);
    grab(b);
    asserts++;
    if (tmo) begin
      fails++;
      $display("FAIL frame_tick_timeout dut=%0d got no tick, need one within 64 cycles", b);
    end
  endtask
  task automatic test_reset();
    int n, lit;
    rst_n = 1'b0; rst_n_b = 1'b0;
    bcd = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0; brightness = 4'hF;
    repeat (3) @(negedge clk);
    asserts++;
    if ({seg_a, dp_a, sel_a, ft_a} !== 13'h0000) begin
      fails++;
      $display("FAIL reset_a got seg=%b dp=%b sel=%b ft=%b need all 0", seg_a, dp_a, sel_a, ft_a);
    end
    asserts++;
    if ({seg_b, dp_b, sel_b, ft_b} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL reset_b got seg=%b dp=%b sel=%b ft=%b need 1111111 1 1111 0", seg_b, dp_b, sel_b, ft_b);
    end
    rst_n = 1'b1; rst_n_b = 1'b1;
    n = 0; lit = 0;
    do begin
      @(negedge clk);
      n++;
      if (sel_a !== 4'b0000 || seg_a !== 7'd0) lit++;
    end while (ft_a !== 1'b1 && n < 40);
    asserts++;
    if (n != 16) begin
      fails++;
      $display("FAIL first_tick got cycle %0d need 16", n);
    end
    asserts++;
    if (lit != 0) begin
      fails++;
      $display("FAIL first_frame_dark got %0d lit cycles need 0", lit);
    end
    asserts++;
    if (ft_b !== 1'b1) begin
      fails++;
      $display("FAIL first_tick_b got %b need 1", ft_b);
    end
  endtask
  task automatic test_scan();
    grab(0);
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gs[i] !== 4'(1) << (i / 4)) begin
        fails++;
        $display("FAIL scan_sel[%0d] got %b need %b", i, gs[i], 4'(1) << (i / 4));
      end
      asserts++;
      if (gt[i] !== (i == 15)) begin
        fails++;
        $display("FAIL scan_tick[%0d] got %b need %b", i, gt[i], i == 15);
      end
    end
  endtask
  task automatic test_decode();
    logic [6:0] e[4];
    grab(0);
    e = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gg[i] !== e[i / 4]) begin
        fails++;
        $display("FAIL decode_1234[%0d] got %b need %b", i, gg[i], e[i / 4]);
      end
    end
    bcd = 16'h00AB;
    next_frame(0);
    e = '{7'h40, 7'h40, 7'h3F, 7'h3F};
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gg[i] !== e[i / 4]) begin
        fails++;
        $display("FAIL decode_00ab[%0d] got %b need %b", i, gg[i], e[i / 4]);
      end
    end
  endtask
  task automatic test_blanking();
    logic [6:0] e[4];
    bcd = 16'h0050; blank_lz = 1'b1;
    next_frame(0);
    e = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gg[i] !== e[i / 4] || gs[i] !== 4'(1) << (i / 4)) begin
        fails++;
        $display("FAIL blank_0050[%0d] got seg=%b sel=%b need seg=%b sel=%b", i, gg[i], gs[i], e[i / 4], 4'(1) << (i / 4));
      end
    end
    bcd = 16'h0000;
    next_frame(0);
    e = '{7'h3F, 7'h00, 7'h00, 7'h00};
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gg[i] !== e[i / 4]) begin
        fails++;
        $display("FAIL blank_0000[%0d] got %b need %b", i, gg[i], e[i / 4]);
      end
    end
  endtask
  task automatic test_tear_free();
    blank_lz = 1'b0; bcd = 16'h1111; dp_in = 4'b0000;
    wait_tick(0);
    asserts++;
    if (tmo) begin
      fails++;
      $display("FAIL tear_tick_timeout got no tick need one within 64 cycles");
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      asserts++;
      if (seg_a !== 7'h06 || dp_a !== 1'b0) begin
        fails++;
        $display("FAIL tear_old[%0d] got seg=%b dp=%b need seg=0000110 dp=0", i, seg_a, dp_a);
      end
      if (i == 5) begin
        bcd = 16'h2222; dp_in = 4'b0100;
      end
    end
    grab(0);
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gg[i] !== 7'h5B || gd[i] !== (gs[i] == 4'b0100)) begin
        fails++;
        $display("FAIL tear_new[%0d] got seg=%b dp=%b sel=%b need seg=1011011 dp=%b", i, gg[i], gd[i], gs[i], gs[i] == 4'b0100);
      end
    end
  endtask
  task automatic test_brightness();
    logic [3:0] br[3];
    int ex[3];
    int act;
    br = '{4'd4, 4'd0, 4'hF};
    ex = '{4, 0, 16};
    for (int t = 0; t < 3; t++) begin
      brightness = br[t];
      next_frame(0);
      act = 0;
      for (int i = 0; i < 16; i++) if (gs[i] !== 4'b0000) act++;
      asserts++;
      if (act != ex[t]) begin
        fails++;
        $display("FAIL bright_%0d got %0d active cycles need %0d", br[t], act, ex[t]);
      end
    end
  endtask
  task automatic test_polarity();
    int n, lit;
    bcd = 16'h8888; dp_in = 4'b0000; brightness = 4'hF; blank_lz = 1'b0;
    next_frame(1);
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (gs[i] !== ~(4'(1) << (i / 4)) || gg[i] !== 7'h00 || gd[i] !== 1'b1) begin
        fails++;
        $display("FAIL pol_8[%0d] got sel=%b seg=%b dp=%b need sel=%b seg=0000000 dp=1", i, gs[i], gg[i], gd[i], ~(4'(1) << (i / 4)));
      end
    end
    repeat (9) @(negedge clk);
    asserts++;
    if (sel_b !== 4'b1011) begin
      fails++;
      $display("FAIL pol_slot2 got %b need 1011", sel_b);
    end
    rst_n_b = 1'b0;
    #1;
    asserts++;
    if ({seg_b, dp_b, sel_b} !== {7'h7F, 1'b1, 4'hF}) begin
      fails++;
      $display("FAIL pol_async_reset got seg=%b dp=%b sel=%b need 1111111 1 1111", seg_b, dp_b, sel_b);
    end
    @(negedge clk);
    rst_n_b = 1'b1;
    n = 0; lit = 0;
    do begin
      @(negedge clk);
      n++;
      if (sel_b !== 4'hF) lit++;
    end while (ft_b !== 1'b1 && n < 40);
    asserts++;
    if (n != 16 || lit != 0) begin
      fails++;
      $display("FAIL pol_restart got tick at %0d with %0d lit need 16 with 0", n, lit);
    end
    @(negedge clk);
    asserts++;
    if (sel_b !== 4'b1110 || seg_b !== 7'h00) begin
      fails++;
      $display("FAIL pol_restart_sel got sel=%b seg=%b need 1110 0000000", sel_b, seg_b);
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_blanking();
    test_tear_free();
    test_brightness();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no completion need finish before 200000");
    $fatal(1);
  end
endmodule
